// File: rtl/mod_sub_if.sv
// mod_sub_if: operand/result stream bundle for the modular subtractor.
// Carries the A/B input stream, the Z output stream and the RANGE_ERR flag.
// Handshake: a transfer happens on a rising CLK edge where valid && ready;
// a producer may change its payload freely while valid is low, and ready may
// depend combinationally on the downstream ready.
interface mod_sub_if #(
   parameter int IN_BW  = 32,
   parameter int OUT_BW = 32
);
   logic [IN_BW-1:0]  A;
   logic [IN_BW-1:0]  B;
   logic              IN_VALID;
   logic              IN_READY;
   logic [OUT_BW-1:0] Z;
   logic              Z_VALID;
   logic              Z_READY;
   logic              RANGE_ERR;

   // Environment side: produces operands, consumes results.
   modport master (
      output A, B, IN_VALID, Z_READY,
      input  IN_READY, Z, Z_VALID, RANGE_ERR
   );

   // Subtractor side.
   modport slave (
      input  A, B, IN_VALID, Z_READY,
      output IN_READY, Z, Z_VALID, RANGE_ERR
   );
endinterface

// File: rtl/mod_sub.sv
// mod_sub: three-stage pipelined modular subtractor, Z = (A - B) mod MOD,
// for operands already reduced into [0, MOD-1].
// Stage 1 registers the operands, stage 2 forms the raw difference and its
// corrected twin (difference plus MOD), stage 3 picks one based on the borrow.
// Each stage has its own valid bit and loads only when it can pass its
// content on, so bubbles collapse and a full pipe still moves one per clock.
// Optional build macro MOD_SUB_RANGE_CHK_EN: flags operands >= MOD on
// RANGE_ERR, aligned with the matching Z. Without it RANGE_ERR is tied to 0.
module mod_sub #(
   parameter int unsigned MOD    = 32'd4294967291,
   parameter int          IN_BW  = $clog2(MOD),
   parameter int          OUT_BW = $clog2(MOD)
) (
   input logic      CLK,
   input logic      RST,
   mod_sub_if.slave bus
);

   localparam logic [IN_BW-1:0] MOD_IN = IN_BW'(MOD);

   // Stage valid bits; v3 is the output valid.
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;

   // Stage 1 operands.
   logic [IN_BW-1:0] a1, b1;

   // Stage 2 candidates and selector.
   logic [IN_BW-1:0] diff2, corr2;
   logic             sel2;

   // Stage 3 result.
   logic [OUT_BW-1:0] z3;

   // Stage 2 combinational difference: the extra top bit is the borrow.
   logic [IN_BW:0]   sub_full;
   logic [IN_BW-1:0] corr_c;

   // A stage may load when it is empty or its successor will take its content.
   always_comb begin
      rdy3 = !v3 || bus.Z_READY;
      rdy2 = !v2 || rdy3;
      rdy1 = !v1 || rdy2;
   end

   assign bus.IN_READY = rdy1;

   // Raw difference and the wrapped-around alternative; wrap is modulo 2^IN_BW,
   // which brings a borrowed result back into [0, MOD-1].
   always_comb begin
      sub_full = {1'b0, a1} - {1'b0, b1};
      corr_c   = sub_full[IN_BW-1:0] + MOD_IN;
   end

   // Stage 1: capture operands on an input transfer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v1 <= 1'b0;
         a1 <= '0;
         b1 <= '0;
      end else if (rdy1) begin
         v1 <= bus.IN_VALID;
         if (bus.IN_VALID) begin
            a1 <= bus.A;
            b1 <= bus.B;
         end
      end
   end

   // Stage 2: register both candidates and the borrow that chooses between them.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v2    <= 1'b0;
         diff2 <= '0;
         corr2 <= '0;
         sel2  <= 1'b0;
      end else if (rdy2) begin
         v2 <= v1;
         if (v1) begin
            diff2 <= sub_full[IN_BW-1:0];
            corr2 <= corr_c;
            sel2  <= sub_full[IN_BW];
         end
      end
   end

   // Stage 3: final selection; holds while the consumer stalls.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v3 <= 1'b0;
         z3 <= '0;
      end else if (rdy3) begin
         v3 <= v2;
         if (v2) begin
            z3 <= OUT_BW'(sel2 ? corr2 : diff2);
         end
      end
   end

   assign bus.Z       = z3;
   assign bus.Z_VALID = v3;

`ifdef MOD_SUB_RANGE_CHK_EN
   localparam int CW = (IN_BW > 32) ? IN_BW : 32;

   logic err_in, err1, err2, err3;

   // Out-of-range detection on the incoming operands.
   always_comb begin
      err_in = (CW'(bus.A) >= CW'(MOD)) || (CW'(bus.B) >= CW'(MOD));
   end

   // Error flag travels with its data, loading under the same stage enables.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err1 <= 1'b0;
         err2 <= 1'b0;
         err3 <= 1'b0;
      end else begin
         if (rdy1 && bus.IN_VALID) err1 <= err_in;
         if (rdy2 && v1)           err2 <= err1;
         if (rdy3 && v2)           err3 <= err2;
      end
   end

   assign bus.RANGE_ERR = err3 && v3;
`else
   assign bus.RANGE_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub.sv
// tb_mod_sub: randomized and directed bench for mod_sub with a queue-based
// reference model of (A - B) mod MOD.
module tb_mod_sub;

   localparam int unsigned MOD    = 32'd4294967291;
   localparam int          IN_BW  = 32;
   localparam int          OUT_BW = 32;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   mod_sub_if #(.IN_BW(IN_BW), .OUT_BW(OUT_BW)) bus ();

   mod_sub #(.MOD(MOD), .IN_BW(IN_BW), .OUT_BW(OUT_BW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // ---------------- scoreboard state ----------------
   // Entry: {z_dont_care, range_err, z}
   logic [OUT_BW+1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int accepts  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [OUT_BW-1:0] ref_sub(input longint unsigned a, input longint unsigned b);
      longint unsigned r;
      if (a >= b) r = a - b;
      else        r = a + longint'(MOD) - b;
      return r[OUT_BW-1:0];
   endfunction

   function automatic logic ref_err(input longint unsigned a, input longint unsigned b);
`ifdef MOD_SUB_RANGE_CHK_EN
      return (a >= longint'(MOD)) || (b >= longint'(MOD));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic z_dont_care(input longint unsigned a, input longint unsigned b);
`ifdef MOD_SUB_RANGE_CHK_EN
      return 1'b0;
`else
      return (a >= longint'(MOD)) || (b >= longint'(MOD));
`endif
   endfunction

   // ---------------- driver: one clock of stimulus + scoring ----------------
   task automatic cycle(input logic iv, input logic [IN_BW-1:0] a,
                        input logic [IN_BW-1:0] b, input logic zr);
      logic              in_fire;
      logic [OUT_BW+1:0] e;
      bus.IN_VALID = iv;
      bus.A        = a;
      bus.B        = b;
      bus.Z_READY  = zr;
      @(negedge CLK);
      // Pipe holds at most 3; it refuses input only when full and stalled.
      check("in_ready", bus.IN_READY, (exp_q.size() < 3) || zr);
      in_fire = iv && bus.IN_READY;
      if (exp_q.size() == 0) begin
         check("z_valid_idle", bus.Z_VALID, 1'b0);
      end else if (bus.Z_VALID) begin
         e = exp_q[0];
         if (!e[OUT_BW+1]) check("z", bus.Z, e[OUT_BW-1:0]);
         check("range_err", bus.RANGE_ERR, e[OUT_BW]);
         if (zr) void'(exp_q.pop_front());
      end
      if (in_fire) begin
         exp_q.push_back({z_dont_care(a, b), ref_err(a, b), ref_sub(a, b)});
         accepts++;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         cycle(1'b0, '0, '0, 1'b1);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   // Single transaction into an empty pipe; checks the 3-clock latency.
   task automatic send_lat(input logic [IN_BW-1:0] a, input logic [IN_BW-1:0] b,
                           input logic [OUT_BW-1:0] expz);
      bus.IN_VALID = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.Z_READY  = 1'b1;
      @(negedge CLK);
      check("lat_in_ready", bus.IN_READY, 1'b1);
      @(posedge CLK);
      #1;
      bus.IN_VALID = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge CLK);
         check("lat_early_valid", bus.Z_VALID, 1'b0);
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      check("lat_valid", bus.Z_VALID, 1'b1);
      check("lat_z", bus.Z, expz);
      @(posedge CLK);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      RST          = 1'b1;
      bus.IN_VALID = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      bus.Z_READY  = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_z_valid", bus.Z_VALID, 1'b0);
      check("rst_z", bus.Z, 0);
      check("rst_range_err", bus.RANGE_ERR, 1'b0);
      check("rst_in_ready", bus.IN_READY, 1'b1);
      RST = 1'b0;

      // Directed values, including boundaries.
      send_lat(32'd10, 32'd3, 32'd7);
      send_lat(32'd3, 32'd10, 32'd4294967284);
      send_lat(32'd5, 32'd5, 32'd0);
      send_lat(32'd0, 32'd4294967290, 32'd1);
      send_lat(32'd4294967290, 32'd0, 32'd4294967290);

      // Back-to-back random stream.
      accepts = 0;
      for (int i = 0; i < 1000; i++) begin
         cycle(1'b1, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1'b1);
      end
      check("stream_accepts", accepts, 1000);
      drain();

      // Backpressure: consumer stalls while producer keeps offering.
      accepts = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 32'(100 + i), 32'(i), 1'b0);
      end
      check("bp_accepts", accepts, 3);
      drain();

      // Sparse input with a randomly stalling consumer.
      for (int i = 0; i < 600; i++) begin
         cycle((i % 3) == 0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
               1'($urandom_range(0, 1)));
      end
      drain();

      // Reset with three results in flight: they must never appear.
      accepts = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'(50 + i), 32'd7, 1'b0);
      end
      check("pre_rst_accepts", accepts, 3);
      bus.IN_VALID = 1'b0;
      RST = 1'b1;
      #1;
      check("rst_async_z_valid", bus.Z_VALID, 1'b0);
      check("rst_async_in_ready", bus.IN_READY, 1'b1);
      exp_q.delete();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '0, '0, 1'b1);
      end
      send_lat(32'd20, 32'd7, 32'd13);

      // Range flag: out-of-range pair then an in-range pair.
      cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
      cycle(1'b1, 32'd4, 32'd2, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
